// File: rtl/md5_pkg.sv
// MD5 step scheduler shared definitions.
// Holds the FSM states, round constants, shift table, IV and message index.
package md5_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FINAL
  } state_t;

  localparam logic [31:0] IV_A = 32'h67452301;
  localparam logic [31:0] IV_B = 32'hefcdab89;
  localparam logic [31:0] IV_C = 32'h98badcfe;
  localparam logic [31:0] IV_D = 32'h10325476;

  // T[i] = floor(2^32 * |sin(i+1)|)
  localparam logic [31:0] T_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756,
    32'h242070db, 32'hc1bdceee,
    32'hf57c0faf, 32'h4787c62a,
    32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af,
    32'hffff5bb1, 32'h895cd7be,
    32'h6b901122, 32'hfd987193,
    32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340,
    32'h265e5a51, 32'he9b6c7aa,
    32'hd62f105d, 32'h02441453,
    32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6,
    32'hf4d50d87, 32'h455a14ed,
    32'ha9e3e905, 32'hfcefa3f8,
    32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681,
    32'h6d9d6122, 32'hfde5380c,
    32'ha4beea44, 32'h4bdecfa9,
    32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa,
    32'hd4ef3085, 32'h04881d05,
    32'hd9d4d039, 32'he6db99e5,
    32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97,
    32'hab9423a7, 32'hfc93a039,
    32'h655b59c3, 32'h8f0ccc92,
    32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0,
    32'ha3014314, 32'h4e0811a1,
    32'hf7537e82, 32'hbd3af235,
    32'h2ad7d2bb, 32'heb86d391
  };

  // indexed by {round, i[1:0]}
  localparam logic [4:0] S_TAB [16] = '{
    5'd7, 5'd12, 5'd17, 5'd22,
    5'd5, 5'd9,  5'd14, 5'd20,
    5'd4, 5'd11, 5'd16, 5'd23,
    5'd6, 5'd10, 5'd15, 5'd21
  };

  function automatic logic [4:0] s_of(
    input logic [5:0] i
  );
    return S_TAB[{i[5:4], i[1:0]}];
  endfunction

  // 4-bit arithmetic wraps mod 16
  function automatic logic [3:0] g_of(
    input logic [5:0] i
  );
    logic [3:0] k;
    logic [3:0] g;
    k = i[3:0];
    g = k;
    unique case (i[5:4])
      2'd0: g = k;
      2'd1: g = (k << 2) + k + 4'd1;
      2'd2: g = (k << 1) + k + 4'd5;
      2'd3: g = (k << 3) - k;
      default: g = k;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rodadas.sv
// MD5 single step unit: b + ((a + F + x + t) <<< s).
// Captures on the falling edge so the result is ready for the next rise.
module rodadas (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [1:0]  e,
  input  logic [31:0] x,
  input  logic [31:0] s,
  input  logic [31:0] t,
  output logic [31:0] output_A
);

  logic [31:0] w_f;
  logic [31:0] w_sum;
  logic [31:0] w_rot;

  always_comb begin
    w_f = '0;
    unique case (e)
      2'd0: w_f = (b & c) | (~b & d);
      2'd1: w_f = (b & d) | (c & ~d);
      2'd2: w_f = b ^ c ^ d;
      2'd3: w_f = c ^ (b | ~d);
      default: w_f = '0;
    endcase
  end

  assign w_sum = a + w_f + x + t;
  assign w_rot = (w_sum << s)
               | (w_sum >> (32'd32 - s));

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_A <= '0;
    end else begin
      output_A <= b + w_rot;
    end
  end

endmodule

// File: rtl/md5_step_scheduler.sv
// MD5 block scheduler: one step per clock through rodadas.
// 64 RUN cycles, one FINAL cycle adds the latched chain.
module md5_step_scheduler
  import md5_pkg::*;
(
  input  logic         PCLK_IN,
  input  logic         PRESETn_IN,
  input  logic         start_in,
  input  logic [511:0] block_in,
  input  logic [127:0] chain_in,
  output logic         ready_out,
  output logic         busy_out,
  output logic         done_out,
  output logic [127:0] digest_out
);

  state_t       r_state;
  logic [5:0]   r_i;
  logic [31:0]  r_a;
  logic [31:0]  r_b;
  logic [31:0]  r_c;
  logic [31:0]  r_d;
  logic [511:0] r_blk;
  logic [127:0] r_chain;
  logic [127:0] r_digest;
  logic         r_done;
  logic         r_ready;
  logic         r_busy;

  logic [3:0]   w_g;
  logic [31:0]  w_x;
  logic [31:0]  w_s;
  logic [31:0]  w_t;
  logic [31:0]  w_step;

  assign w_g = g_of(r_i);
  assign w_x = r_blk[{w_g, 5'd0} +: 32];
  assign w_s = {27'd0, s_of(r_i)};
  assign w_t = T_TAB[r_i];

  rodadas u_step (
    .clk      (PCLK_IN),
    .rst_n    (PRESETn_IN),
    .a        (r_a),
    .b        (r_b),
    .c        (r_c),
    .d        (r_d),
    .e        (r_i[5:4]),
    .x        (w_x),
    .s        (w_s),
    .t        (w_t),
    .output_A (w_step)
  );

  always_ff @(posedge PCLK_IN or negedge PRESETn_IN) begin
    if (!PRESETn_IN) begin
      r_state  <= ST_IDLE;
      r_i      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_c      <= '0;
      r_d      <= '0;
      r_blk    <= '0;
      r_chain  <= '0;
      r_digest <= '0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            r_blk   <= block_in;
            r_chain <= chain_in;
            r_a     <= chain_in[31:0];
            r_b     <= chain_in[63:32];
            r_c     <= chain_in[95:64];
            r_d     <= chain_in[127:96];
            r_i     <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_a <= r_d;
          r_d <= r_c;
          r_c <= r_b;
          r_b <= w_step;
          r_i <= r_i + 6'd1;
          if (r_i == 6'd63) begin
            r_state <= ST_FINAL;
          end
        end
        ST_FINAL: begin
          r_digest <= {
            r_chain[127:96] + r_d,
            r_chain[95:64]  + r_c,
            r_chain[63:32]  + r_b,
            r_chain[31:0]   + r_a
          };
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready_out  = r_ready;
  assign busy_out   = r_busy;
  assign done_out   = r_done;
  assign digest_out = r_digest;

endmodule

// File: tb/tb_md5_step_scheduler.sv
// Self-checking bench for md5_step_scheduler.
// Reference: plain MD5 compression with sine-derived constants.
module tb_md5_step_scheduler;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [511:0] blk;
  logic [127:0] chn;
  logic         ready;
  logic         busy;
  logic         done;
  logic [127:0] dig;

  int n_tests;
  int n_fail;

  logic [31:0] K [64];

  localparam logic [127:0] IV =
    128'h10325476_98badcfe_efcdab89_67452301;
  localparam logic [127:0] D_EMPTY =
    128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;
  localparam logic [127:0] D_ABC =
    128'h727fe128_7d3f96d6_b04fd23c_98500190;

  md5_step_scheduler dut (
    .PCLK_IN    (clk),
    .PRESETn_IN (rst_n),
    .start_in   (start),
    .block_in   (blk),
    .chain_in   (chn),
    .ready_out  (ready),
    .busy_out   (busy),
    .done_out   (done),
    .digest_out (dig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rotl(
    input logic [31:0] v,
    input int          n
  );
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic int shamt(input int i);
    int r;
    int k;
    r = i / 16;
    k = i % 4;
    case (r)
      0: return (k == 0) ? 7 : (k == 1) ? 12 : (k == 2) ? 17 : 22;
      1: return (k == 0) ? 5 : (k == 1) ? 9 : (k == 2) ? 14 : 20;
      2: return (k == 0) ? 4 : (k == 1) ? 11 : (k == 2) ? 16 : 23;
      default: return (k == 0) ? 6 : (k == 1) ? 10 : (k == 2) ? 15 : 21;
    endcase
  endfunction

  function automatic logic [127:0] md5_ref(
    input logic [511:0] m,
    input logic [127:0] cv
  );
    logic [31:0] a, b, c, d, f, tmp;
    int g;
    a = cv[31:0];
    b = cv[63:32];
    c = cv[95:64];
    d = cv[127:96];
    for (int i = 0; i < 64; i++) begin
      case (i / 16)
        0: begin f = (b & c) | (~b & d); g = i; end
        1: begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
        2: begin f = b ^ c ^ d; g = (3 * i + 5) % 16; end
        default: begin f = c ^ (b | ~d); g = (7 * i) % 16; end
      endcase
      tmp = d;
      d = c;
      c = b;
      b = b + rotl(a + f + K[i] + m[32*g +: 32], shamt(i));
      a = tmp;
    end
    return {cv[127:96] + d, cv[95:64] + c,
            cv[63:32] + b, cv[31:0] + a};
  endfunction

  function automatic logic [511:0] rand_blk();
    logic [511:0] v;
    for (int j = 0; j < 16; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [127:0] rand_chn();
    logic [127:0] v;
    for (int j = 0; j < 4; j++) v[32*j +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // accept edge happens inside; returns just after it
  task automatic start_blk(
    input logic [511:0] b,
    input logic [127:0] c
  );
    int w;
    w = 0;
    while (!ready && w < 100) begin tick(); w++; end
    blk = b;
    chn = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(
    input  bit scramble,
    output int cyc
  );
    cyc = 0;
    while (!done && cyc < 200) begin
      tick();
      cyc++;
      if (scramble) begin
        blk = rand_blk();
        chn = rand_chn();
      end
    end
  endtask

  logic [511:0] m_empty;
  logic [511:0] m_abc;
  logic [511:0] rb;
  logic [127:0] rc;
  logic [127:0] exp_d;
  int           cyc;
  int           pulses;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 64; i++) begin
      real sv;
      sv = $sin(real'(i + 1));
      if (sv < 0.0) sv = -sv;
      K[i] = 32'(longint'($floor(4294967296.0 * sv)));
    end
    m_empty = '0;
    m_empty[31:0] = 32'h00000080;
    m_abc = '0;
    m_abc[31:0] = 32'h80636261;
    m_abc[32*14 +: 32] = 32'h00000018;

    rst_n = 1'b0;
    start = 1'b0;
    blk = '0;
    chn = '0;
    repeat (3) tick();
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_digest", dig, 128'd0);
    rst_n = 1'b1;
    tick();

    // empty message
    start_blk(m_empty, IV);
    check("empty_busy", 128'(busy), 128'd1);
    wait_done(1'b0, cyc);
    check("empty_lat", 128'(cyc), 128'd65);
    check("empty_dig", dig, D_EMPTY);
    check("empty_model", dig, md5_ref(m_empty, IV));
    check("done_ready", 128'(ready), 128'd1);
    tick();
    check("done_drop", 128'(done), 128'd0);
    check("hold_dig", dig, D_EMPTY);

    // abc
    start_blk(m_abc, IV);
    wait_done(1'b0, cyc);
    check("abc_lat", 128'(cyc), 128'd65);
    check("abc_dig", dig, D_ABC);

    // start held high mid-block
    blk = m_abc;
    chn = IV;
    start = 1'b1;
    tick();
    pulses = 0;
    for (int k = 1; k < 30; k++) begin
      tick();
      if (done) pulses++;
    end
    start = 1'b0;
    wait_done(1'b0, cyc);
    check("hold_lat", 128'(cyc + 29), 128'd65);
    check("hold_dig", dig, D_ABC);
    for (int k = 0; k < 80; k++) begin
      tick();
      if (done) pulses++;
    end
    check("hold_pulses", 128'(pulses), 128'd0);

    // back-to-back
    start_blk(m_empty, IV);
    wait_done(1'b0, cyc);
    check("b2b_dig0", dig, D_EMPTY);
    check("b2b_ready", 128'(ready), 128'd1);
    blk = m_abc;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b_busy", 128'(busy), 128'd1);
    wait_done(1'b0, cyc);
    check("b2b_lat", 128'(cyc), 128'd65);
    check("b2b_dig1", dig, D_ABC);

    // reset mid-block
    start_blk(m_empty, IV);
    repeat (20) tick();
    rst_n = 1'b0;
    #1;
    check("arst_done", 128'(done), 128'd0);
    check("arst_dig", dig, 128'd0);
    check("arst_ready", 128'(ready), 128'd1);
    check("arst_busy", 128'(busy), 128'd0);
    #2;
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 70; k++) begin
      tick();
      if (done) pulses++;
    end
    check("arst_pulses", 128'(pulses), 128'd0);
    start_blk(m_abc, IV);
    wait_done(1'b0, cyc);
    check("arst_abc", dig, D_ABC);

    // inputs scrambled after acceptance
    rb = rand_blk();
    rc = rand_chn();
    exp_d = md5_ref(rb, rc);
    start_blk(rb, rc);
    wait_done(1'b1, cyc);
    check("scr_lat", 128'(cyc), 128'd65);
    check("scr_dig", dig, exp_d);

    // random blocks and chains
    for (int n = 0; n < 6; n++) begin
      rb = rand_blk();
      rc = (n == 0) ? IV : rand_chn();
      start_blk(rb, rc);
      wait_done(1'b0, cyc);
      check("rnd_lat", 128'(cyc), 128'd65);
      check("rnd_dig", dig, md5_ref(rb, rc));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
